// File: rtl/index_decoder_frame.sv
// Decodes a stream of indices into one-hot bits, OR-accumulates them over a
// frame and presents the frame through a one-entry valid/ready output register.
module index_decoder_frame #(
    parameter  int WIDTH          = 32,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_vld,
    output logic                 enc_rdy,
    input  logic [WIDTH_LOG-1:0] enc_idx,
    input  logic                 enc_lst,
    output logic [WIDTH-1:0]     dec_vld,
    output logic                 frm_vld,
    input  logic                 frm_rdy,
    output logic [WIDTH_LOG:0]   frm_cnt,
    output logic                 frm_dup,
    output logic                 frm_err
);

    logic [WIDTH-1:0]   raw;
    logic [WIDTH-1:0]   hot;
    logic               in_range;
    logic               dup_hit;
    logic               new_bit;
    logic               take;

    logic [WIDTH-1:0]   m_acc;
    logic [WIDTH_LOG:0] m_cnt;
    logic               m_dup;
    logic               m_err;

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH_LOG:0] cnt_q, cnt_d;
    logic               dup_q, dup_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   dec_q, dec_d;
    logic [WIDTH_LOG:0] fcnt_q, fcnt_d;
    logic               fdup_q, fdup_d;
    logic               ferr_q, ferr_d;
    logic               fvld_q, fvld_d;

    // Out-of-range indices only exist when WIDTH is not a power of two.
    if (WIDTH == (1 << WIDTH_LOG)) begin : g_full_range
        assign in_range = 1'b1;
    end else begin : g_part_range
        assign in_range = (32'(enc_idx) < 32'(WIDTH));
    end

    if (IMPLEMENTATION == 0) begin : g_shift
        assign raw = {{(WIDTH-1){1'b0}}, 1'b1} << enc_idx;
    end else if (IMPLEMENTATION == 1) begin : g_cmp
        always_comb begin
            raw = '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                raw[i] = (32'(enc_idx) == i);
            end
        end
    end else begin : g_bad
        $error("index_decoder_frame: IMPLEMENTATION must be 0 or 1");
        assign raw = '0;
    end

    assign hot     = in_range ? raw : '0;
    assign dup_hit = |(acc_q & hot);
    assign new_bit = in_range & ~dup_hit;

    assign m_acc = acc_q | hot;
    assign m_cnt = cnt_q + (WIDTH_LOG+1)'(new_bit);
    assign m_dup = dup_q | dup_hit;
    assign m_err = err_q | ~in_range;

    assign enc_rdy = ~fvld_q | frm_rdy;
    assign take    = enc_vld & enc_rdy;

    // A last beat loads the output register even while it is being drained,
    // so frm_vld stays high for back-to-back single-beat frames.
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        dup_d  = dup_q;
        err_d  = err_q;
        dec_d  = dec_q;
        fcnt_d = fcnt_q;
        fdup_d = fdup_q;
        ferr_d = ferr_q;
        fvld_d = fvld_q;
        if (fvld_q && frm_rdy) begin
            fvld_d = 1'b0;
        end
        if (take) begin
            if (enc_lst) begin
                dec_d  = m_acc;
                fcnt_d = m_cnt;
                fdup_d = m_dup;
                ferr_d = m_err;
                fvld_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
                dup_d  = 1'b0;
                err_d  = 1'b0;
            end else begin
                acc_d  = m_acc;
                cnt_d  = m_cnt;
                dup_d  = m_dup;
                err_d  = m_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            dup_q  <= 1'b0;
            err_q  <= 1'b0;
            dec_q  <= '0;
            fcnt_q <= '0;
            fdup_q <= 1'b0;
            ferr_q <= 1'b0;
            fvld_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            dup_q  <= dup_d;
            err_q  <= err_d;
            dec_q  <= dec_d;
            fcnt_q <= fcnt_d;
            fdup_q <= fdup_d;
            ferr_q <= ferr_d;
            fvld_q <= fvld_d;
        end
    end

    assign dec_vld = dec_q;
    assign frm_vld = fvld_q;
    assign frm_cnt = fcnt_q;
    assign frm_dup = fdup_q;
    assign frm_err = ferr_q;

endmodule
